// File: rtl/mod_counter_ctrl.sv
// Start/stop/clear/load counter controller with configurable wrap-or-stop boundary behaviour.
// Optional blinking alarm on terminal count is enabled by defining MOD_COUNTER_CTRL_ALARM_EN.
module mod_counter_ctrl #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] LIMIT = 8'd99,
    parameter bit               WRAP  = 1'b1
) (
    input  logic             clk_1hz,
    input  logic             i_nrst,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_dir,
    output logic [WIDTH-1:0] o_value,
    output logic [1:0]       o_state,
    output logic             o_running,
    output logic             o_tc,
    output logic             o_alarm
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO = '0;

    state_t           state;
    logic [WIDTH-1:0] value;
    logic             tc;
    logic             start_q, stop_q, clear_q, load_q;

    logic             do_clear, do_load, do_stop, do_start;
    logic             step_en, boundary_hit;
    logic [WIDTH-1:0] load_sat;

    // Rising-edge detect, then priority clear > load > stop > start; losers are dropped.
    always_comb begin
        do_clear     = i_clear & ~clear_q;
        do_load      = i_load  & ~load_q  & ~do_clear;
        do_stop      = i_stop  & ~stop_q  & ~do_clear & ~do_load;
        do_start     = i_start & ~start_q & ~do_clear & ~do_load & ~do_stop;
        load_sat     = (i_load_value > LIMIT) ? LIMIT : i_load_value;
        step_en      = (state == RUN) & ~do_clear & ~do_load & ~do_stop & ~do_start;
        boundary_hit = step_en & (i_dir ? (value == ZERO) : (value == LIMIT));
    end

    always_ff @(posedge clk_1hz or negedge i_nrst) begin
        if (!i_nrst) begin
            state   <= IDLE;
            value   <= ZERO;
            tc      <= 1'b0;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            clear_q <= 1'b0;
            load_q  <= 1'b0;
        end else begin
            start_q <= i_start;
            stop_q  <= i_stop;
            clear_q <= i_clear;
            load_q  <= i_load;
            tc      <= boundary_hit;
            case (state)
                IDLE: begin
                    if (do_clear)      value <= ZERO;
                    else if (do_load)  value <= load_sat;
                    else if (do_start) state <= RUN;
                end
                RUN: begin
                    if (do_clear) begin
                        state <= IDLE;
                        value <= ZERO;
                    end else if (do_load) begin
                        value <= load_sat;
                    end else if (do_stop) begin
                        state <= PAUSE;
                    end else if (boundary_hit) begin
                        // Without wrap the value holds at the boundary it just reached.
                        if (WRAP) value <= i_dir ? LIMIT : ZERO;
                        else      state <= DONE;
                    end else if (step_en) begin
                        value <= i_dir ? (value - ONE) : (value + ONE);
                    end
                end
                PAUSE: begin
                    if (do_clear) begin
                        state <= IDLE;
                        value <= ZERO;
                    end else if (do_load) begin
                        value <= load_sat;
                    end else if (do_start) begin
                        state <= RUN;
                    end
                end
                DONE: begin
                    if (do_clear) begin
                        state <= IDLE;
                        value <= ZERO;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MOD_COUNTER_CTRL_ALARM_EN
    logic alarm_latch;
    logic alarm;

    // Entry to DONE is always a boundary hit, so one set condition covers both causes.
    always_ff @(posedge clk_1hz or negedge i_nrst) begin
        if (!i_nrst) begin
            alarm_latch <= 1'b0;
            alarm       <= 1'b0;
        end else if (do_clear) begin
            alarm_latch <= 1'b0;
            alarm       <= 1'b0;
        end else if (alarm_latch) begin
            alarm       <= ~alarm;
        end else if (boundary_hit) begin
            alarm_latch <= 1'b1;
            alarm       <= 1'b1;
        end
    end

    assign o_alarm = alarm;
`else
    assign o_alarm = 1'b0;
`endif

    assign o_value   = value;
    assign o_state   = state;
    assign o_running = (state == RUN);
    assign o_tc      = tc;

endmodule

// File: doc/mod_counter_ctrl.md
MOD_COUNTER_CTRL -- requirements
Module: mod_counter_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, is the counter and value bus width in bits.
REQ-002 Parameter LIMIT, default 8'd99, is the terminal count (WIDTH bits; LIMIT > 0).
REQ-003 Parameter WRAP, default 1: 1 = wrap at the boundary and keep running; 0 = stop in DONE.
REQ-004 clk_1hz  input  1  system tick clock; all state updates on its rising edge.
REQ-005 i_nrst  input  1  reset, asynchronous, active-low.
REQ-006 i_start  input  1  level request to start or resume counting.
REQ-007 i_stop  input  1  level request to pause counting.
REQ-008 i_clear  input  1  level request to zero the value and return to IDLE.
REQ-009 i_load  input  1  level request to load i_load_value.
REQ-010 i_load_value  input  WIDTH  value applied on a load.
REQ-011 i_dir  input  1  count direction: 0 = up, 1 = down; sampled every cycle.
REQ-012 o_value  output  WIDTH  current count, fed to the byte display.
REQ-013 o_state  output  2  state encoding: IDLE=00, RUN=01, PAUSE=10, DONE=11.
REQ-014 o_running  output  1  high iff state is RUN.
REQ-015 o_tc  output  1  one-cycle terminal-count pulse.
REQ-016 o_alarm  output  1  blinking alarm indicator (see Configuration).

Function
REQ-017 Each request SHALL be rising-edge detected against a registered copy of itself; a held level SHALL act only once.
REQ-018 A request SHALL take effect at the first clk_1hz edge that samples it high; its result SHALL be visible after that edge (1-cycle latency).
REQ-019 Priority for requests on the same edge SHALL be clear > load > stop > start; only the winner acts and the others are discarded.
REQ-020 IDLE: start -> RUN; load -> o_value = min(i_load_value, LIMIT), stay in IDLE; stop has no effect.
REQ-021 RUN: on each edge with no winning request, o_value SHALL step +1 (i_dir=0) or -1 (i_dir=1).
REQ-022 RUN: stop -> PAUSE with no step on that edge; load -> load the value, stay in RUN, no step on that edge; clear -> IDLE with o_value=0.
REQ-023 PAUSE: o_value holds; start -> RUN (first step on the following edge); load loads the value and stays in PAUSE; clear -> IDLE with o_value=0.
REQ-024 Boundary when counting up at o_value==LIMIT: WRAP=1 -> o_value=0 and stay in RUN; WRAP=0 -> hold LIMIT and go to DONE.
REQ-025 Boundary when counting down at o_value==0: WRAP=1 -> o_value=LIMIT and stay in RUN; WRAP=0 -> hold 0 and go to DONE.
REQ-026 o_tc SHALL be high for exactly the one cycle following each boundary event in REQ-024/025, and low otherwise.
REQ-027 DONE: o_value holds; start, stop and load are ignored; only clear exits, to IDLE with o_value=0.
REQ-028 o_value SHALL never exceed LIMIT; arithmetic is WIDTH-bit with no carry out.

Reset
REQ-029 While i_nrst is low: o_value=0, state=IDLE, o_tc=0, o_alarm=0, all edge-detect registers=0.
REQ-030 Reset SHALL override any in-progress operation immediately and without reference to the clock.
REQ-031 A request held high through reset release SHALL act at the first edge after release.

Configuration
REQ-032 Macro MOD_COUNTER_CTRL_ALARM_EN, when defined: an alarm latch SHALL set on o_tc or on entry to DONE, and SHALL clear only on clear or reset.
REQ-033 With the macro defined and the latch set, o_alarm SHALL toggle every cycle, starting high on the cycle the latch sets.
REQ-034 Without the macro: o_alarm SHALL be constant 0 and no alarm latch logic SHALL exist.

Verification
REQ-035 Reset, pulse start, 5 edges with i_dir=0 -> o_value=5, o_state=01, o_running=1.
REQ-036 WRAP=1, LIMIT=99, load 98 in RUN, up-count 2 edges -> o_value 99 then 0; o_tc high for one cycle after the 99->0 step.
REQ-037 WRAP=0, load 1 in RUN, i_dir=1, 2 edges -> o_value 0, o_state=11; a further start is ignored; clear -> o_value=0, o_state=00.
REQ-038 clear, load and start all rising on one edge with o_value=7 -> o_value=0, o_state=00; start held afterwards causes no transition.
REQ-039 Load 200 with LIMIT=99 -> o_value=99; stop in RUN at 42, then 3 edges -> value holds at 42, o_state=10.
REQ-040 ALARM_EN defined, reach DONE -> o_alarm toggles 1,0,1...; assert i_nrst low mid-count -> all outputs zero immediately.
